// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the elastic pipeline stage register
//   pipe_state_t : occupancy of the stage (EMPTY, HALF = main only, FULL = main + skid)
//   SKID_DEPTH   : number of payload entries held by one stage
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY, HALF, FULL} pipe_state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating event counter that holds at all-ones instead of wrapping
//   CLK   in   clock, rising edge
//   nRST  in   asynchronous active-low reset, clears count
//   inc   in   count this cycle
//   count out  current count
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) count_q <= '0;
        else       count_q <= count_d;
    assign count = count_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with 2-entry skid buffer, flush and sticky halt
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   flush                synchronous clear of all entries, highest priority
//   in_valid/in_ready    upstream handshake; in_ready depends on registered state only
//   in_data/in_halt      upstream payload and halt tag
//   out_valid/out_ready  downstream handshake
//   out_data/out_halt    head entry payload and halt tag (RST_DATA/0 while empty)
//   stall_cnt/bubble_cnt saturating statistics, present only when PIPE_STATS_EN is defined
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                CNT_W    = 16,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);
    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              main_halt_q, main_halt_d, skid_halt_q, skid_halt_d;
    logic              halted_q, halted_d;
    logic              push, pop;

    assign in_ready  = (state_q != FULL) & !halted_q;
    assign out_valid = state_q != EMPTY;
    assign out_data  = out_valid ? main_q : RST_DATA;
    assign out_halt  = out_valid & main_halt_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The skid entry only fills when the head stalls, so in_ready never depends on out_ready.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        main_halt_d = main_halt_q;
        skid_halt_d = skid_halt_q;
        halted_d    = halted_q | (push & in_halt);
        if (flush) begin
            state_d  = EMPTY;
            halted_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    state_d     = HALF;
                    main_d      = in_data;
                    main_halt_d = in_halt;
                end
                HALF: if (push && pop) begin
                    main_d      = in_data;
                    main_halt_d = in_halt;
                end else if (push) begin
                    state_d     = FULL;
                    skid_d      = in_data;
                    skid_halt_d = in_halt;
                end else if (pop) begin
                    state_d = EMPTY;
                end
                FULL: if (pop) begin
                    state_d     = HALF;
                    main_d      = skid_q;
                    main_halt_d = skid_halt_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state_q     <= EMPTY;
            main_q      <= RST_DATA;
            skid_q      <= RST_DATA;
            main_halt_q <= 1'b0;
            skid_halt_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            main_halt_q <= main_halt_d;
            skid_halt_q <= skid_halt_d;
            halted_q    <= halted_d;
        end

`ifdef PIPE_STATS_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall (
        .CLK(CLK), .nRST(nRST), .inc(out_valid & !out_ready), .count(stall_cnt)
    );
    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble (
        .CLK(CLK), .nRST(nRST), .inc(!out_valid), .count(bubble_cnt)
    );
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
    localparam int          DW  = 64;
    localparam int          CW  = 4;
    localparam logic [63:0] RST = 64'hDEAD_BEEF_0BAD_F00D;

    logic          CLK = 1'b0, nRST = 1'b0, flush = 1'b0;
    logic          in_valid = 1'b0, in_halt = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid, out_halt;
    logic [DW-1:0] in_data = '0, out_data;
`ifdef PIPE_STATS_EN
    logic [CW-1:0] stall_cnt, bubble_cnt;
`endif
    int            n_assert = 0, n_fail = 0;
    logic [DW:0]   sb[$];

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW), .RST_DATA(RST)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt)
`ifdef PIPE_STATS_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [DW:0] e;
        if (flush) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                e = sb.size() > 0 ? sb.pop_front() : 'x;
                check("pop", {out_halt, out_data}, e);
            end
            if (in_valid && in_ready) sb.push_back({in_halt, in_data});
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, RST);
        check("rst_out_halt", out_halt, 0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        // streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = i;
            check("stream_in_ready", in_ready, 1);
            step();
            if (i == 1) begin
                check("stream_latency_valid", out_valid, 1);
                check("stream_latency_data", out_data, 1);
            end
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", sb.size(), 0);
        check("stream_empty", out_valid, 0);
        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'hA;
        step();
        in_data = 'hB;
        step();
        check("bp_in_ready", in_ready, 0);
        check("bp_head", out_data, 'hA);
        in_data = 'hC;
        step();
        check("bp_head_stable", out_data, 'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("bp_empty", out_valid, 0);
        check("bp_all_delivered", sb.size(), 0);
        // flush while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'hA;
        step();
        in_data = 'hB;
        step();
        in_valid = 1'b0;
        check("fl_full", in_ready, 0);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_out_data", out_data, RST);
        step();
        check("fl_nothing_delivered", out_valid, 0);
        // halt
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'h5;
        in_halt   = 1'b1;
        step();
        in_halt = 1'b0;
        check("halt_in_ready", in_ready, 0);
        in_data = 'h6;
        step();
        check("halt_out_halt", out_halt, 1);
        check("halt_out_data", out_data, 'h5);
        out_ready = 1'b1;
        step();
        check("halt_drained", out_valid, 0);
        check("halt_sticky", in_ready, 0);
        in_data = 'h7;
        step();
        check("halt_refused", out_valid, 0);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check("halt_flush_clears", in_ready, 1);
        check("halt_sb_empty", sb.size(), 0);
        // async reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'hA;
        step();
        in_data = 'hB;
        step();
        in_valid = 1'b0;
        check("ar_full", in_ready, 0);
        #2;
        nRST = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_data", out_data, RST);
        check("ar_in_ready", in_ready, 1);
        check("ar_out_halt", out_halt, 0);
        sb.delete();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check("ar_stays_empty", out_valid, 0);
`ifdef PIPE_STATS_EN
        nRST = 1'b0;
        #1;
        check("st_rst_stall", stall_cnt, 0);
        check("st_rst_bubble", bubble_cnt, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'h9;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("st_stall_sat", stall_cnt, 15);
        check("st_bubble", bubble_cnt, 2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("st_flush_keeps", stall_cnt, 15);
        step();
        check("st_bubble_after_flush", bubble_cnt, 3);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
